// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction-fetch stage with a prefetch queue.
// The stage issues one aligned fetch per cycle to a 1-cycle-latency
// instruction memory. Each returned word is buffered with its PC, and the
// head of the queue goes to decode over a valid/ready handshake.
// A branch or exception redirect flushes the queue and drops the response
// that is still in flight.
// Optional feature macro: FETCH_STATS_EN adds the stall and flush counters.
module if_prefetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              except,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_stall_cnt,
  output logic [31:0]       stat_flush_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] target;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic              redirect;
  logic              room;
  logic              enq;
  logic              deq;

  // Advance a queue pointer. The wrap is explicit so that DEPTH does not
  // have to be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Redirect select: an exception outranks a branch, and the target is word-aligned.
  always_comb begin
    redirect = except | br;
    target = except ? EXC_VECTOR : br_target;
    target[1:0] = 2'b00;
  end

  // Issue decision. A fetch goes out only if its response is sure to have a
  // queue slot, which keeps count + inflight within DEPTH.
  always_comb begin
    room = ({1'b0, count} + (CNT_W + 1)'(inflight)) < (CNT_W + 1)'(DEPTH);
    imem_req = !rst & (redirect | room);
    imem_addr = redirect ? target : pc_q;
    enq = inflight & !redirect;
    deq = id_valid & id_ready;
  end

  // PC, in-flight tracking, and queue pointer/count update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc_q <= imem_addr + ADDR_W'(4);
        inflight_pc <= imem_addr;
      end
      if (redirect) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= ptr_inc(wr_ptr);
        if (deq) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // Queue storage. It needs no reset because the outputs are qualified by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr] <= inflight_pc;
    end
  end

  // Head presentation. The outputs read zero while the queue is empty.
  always_comb begin
    id_valid = (count != '0);
    id_inst = id_valid ? inst_mem[rd_ptr] : '0;
    id_pc = id_valid ? pc_mem[rd_ptr] : '0;
    id_pc_plus4 = id_valid ? pc_mem[rd_ptr] + ADDR_W'(4) : '0;
  end

`ifdef FETCH_STATS_EN
  logic flush_hit;

  // A flush counts only when a redirect throws away real work: a buffered
  // entry that is not being accepted this cycle, or the in-flight response.
  always_comb begin
    flush_hit = redirect & (inflight | (count != CNT_W'(deq)));
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_cnt <= '0;
      stat_flush_cnt <= '0;
    end else begin
      if (id_valid && !id_ready && stat_stall_cnt != '1)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if (flush_hit && stat_flush_cnt != '1)
        stat_flush_cnt <= stat_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: directed bench for if_prefetch_unit with a scoreboard.
// Each stimulus phase pushes the PCs it expects decode to accept. A monitor
// compares PC, instruction and PC+4 on every handshake.
module tb_if_prefetch_unit;
  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        br;
  logic [31:0] br_target;
  logic        except;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_stall_cnt;
  logic [31:0] stat_flush_cnt;
  logic [31:0] snap;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  if_prefetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .br(br), .br_target(br_target), .except(except),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
`ifdef FETCH_STATS_EN
    , .stat_stall_cnt(stat_stall_cnt), .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: the word for the address seen at an edge is returned one cycle later.
  always @(posedge clk) imem_rdata <= imem_addr ^ 32'hA5A5_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Scoreboard monitor. It samples at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake: got pc %h expected none", id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("hs_id_pc", id_pc, e);
        chk("hs_id_inst", id_inst, e ^ 32'hA5A5_0000);
        chk("hs_id_pc_plus4", id_pc_plus4, e + 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_ready = 1'b1; br = 1'b0; except = 1'b0; br_target = '0;
    #2;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);

    // Phase 1: streaming from reset with id_ready held high.
    push_seq(32'h0, 16);
    tick(); rst = 1'b0;
    #1;
    chk("c0_imem_req", 32'(imem_req), 32'd1);
    chk("c0_imem_addr", imem_addr, 32'h0);
    tick();
    chk("c1_id_valid", 32'(id_valid), 32'd0);
    tick();
    chk("c2_id_valid", 32'(id_valid), 32'd1);
    chk("c2_id_pc", id_pc, 32'h0);
    repeat (16) tick();
    id_ready = 1'b0;
    chk("p1_drained", 32'(exp_q.size()), 32'd0);

    // Fill the queue by stalling, then apply an asynchronous reset.
    repeat (6) tick();
    chk("full_imem_req", 32'(imem_req), 32'd0);
    chk("full_head_pc", id_pc, 32'h40);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_id_valid", 32'(id_valid), 32'd0);
    chk("async_rst_imem_req", 32'(imem_req), 32'd0);
    exp_q.delete();
    tick(); tick();

    // Phase 2: a stall from reset, release, then a branch while the head is at 0x10.
    push_seq(32'h0, 5);
    push_seq(32'h100, 4);
    rst = 1'b0;
    repeat (10) tick();
    chk("stall_imem_req", 32'(imem_req), 32'd0);
    chk("stall_id_valid", 32'(id_valid), 32'd1);
    chk("stall_id_pc", id_pc, 32'h0);
    chk("stall_id_inst", id_inst, 32'hA5A5_0000);
    tick();
    chk("stall_id_pc_hold", id_pc, 32'h0);
    id_ready = 1'b1;
    repeat (4) tick();
    chk("pre_br_head", id_pc, 32'h10);
    br = 1'b1; br_target = 32'h100;
    #1 chk("br_imem_addr", imem_addr, 32'h100);
    tick(); br = 1'b0;
    chk("br_bubble_valid", 32'(id_valid), 32'd0);
    tick();
    chk("br_n2_valid", 32'(id_valid), 32'd1);
    chk("br_n2_pc", id_pc, 32'h100);
    repeat (4) tick();
    id_ready = 1'b0;
    chk("p2_drained", 32'(exp_q.size()), 32'd0);

    // Phase 3: branch and exception in the same cycle; the exception wins.
    repeat (2) tick();
    push_seq(32'h8000_0180, 3);
    br = 1'b1; br_target = 32'h200; except = 1'b1;
    #1;
    chk("exc_imem_req", 32'(imem_req), 32'd1);
    chk("exc_imem_addr", imem_addr, 32'h8000_0180);
    tick(); br = 1'b0; except = 1'b0; id_ready = 1'b1;
    chk("exc_bubble_valid", 32'(id_valid), 32'd0);
    tick();
    chk("exc_n2_pc", id_pc, 32'h8000_0180);
    repeat (3) tick();
    id_ready = 1'b0;
    chk("p3_drained", 32'(exp_q.size()), 32'd0);

    // Phase 4: an unaligned branch target is forced to word alignment.
    push_seq(32'h100, 2);
`ifdef FETCH_STATS_EN
    snap = stat_flush_cnt;
`endif
    br = 1'b1; br_target = 32'h103;
    #1 chk("align_imem_addr", imem_addr, 32'h100);
    tick(); br = 1'b0; id_ready = 1'b1;
`ifdef FETCH_STATS_EN
    chk("stat_flush_inc", stat_flush_cnt, snap + 32'd1);
`endif
    tick();
    chk("align_id_pc", id_pc, 32'h100);
    repeat (2) tick();
    id_ready = 1'b0;
    chk("p4_drained", 32'(exp_q.size()), 32'd0);

    // Phase 5: the PC and PC+4 wrap at the top of the address space.
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    br = 1'b1; br_target = 32'hFFFF_FFFC;
    tick(); br = 1'b0; id_ready = 1'b1;
    tick();
    repeat (2) tick();
    id_ready = 1'b0;
    chk("p5_drained", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_STATS_EN
    snap = stat_stall_cnt;
    repeat (3) tick();
    chk("stat_stall_inc", stat_stall_cnt, snap + 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
